// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache block interface: default widths and the
// responder state encoding used by both the caches and the backing memory.
package mem_if_pkg;

  localparam int unsigned MEM_ADDR_W = 28;
  localparam int unsigned MEM_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/block_mem_responder_if.sv
// Cache block interface bundle: the initiator (cache) is the master and the
// memory responder is the slave.
interface block_mem_responder_if #(
  parameter int unsigned ADDR_W = mem_if_pkg::MEM_ADDR_W,
  parameter int unsigned DATA_W = mem_if_pkg::MEM_DATA_W
);

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_err;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, mem_err
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready, mem_err
  );

endinterface

// File: rtl/block_mem_array.sv
// Single-port block storage: synchronous write, asynchronous read, never reset
// so contents survive a responder reset.
module block_mem_array #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/block_mem_responder.sv
// Memory-side responder for the cache block interface: one block transfer at a
// time, completing a fixed LATENCY cycles after the request is accepted.
module block_mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned DATA_W     = MEM_DATA_W,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  block_mem_responder_if.slave bus
);

  generate
    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
      $error("block_mem_responder: LATENCY %0d outside 1..255", LATENCY);
    end
  endgenerate

  localparam logic [7:0] COUNT_INIT = 8'(LATENCY - 1);

  mem_state_e            state, state_nx;
  logic [7:0]            count;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  op_w;
  logic                  err_q;
  logic                  req;
  logic                  op_held;
  logic                  accept;
  logic                  mem_we;
  logic [DATA_W-1:0]     arr_rdata;
  logic                  unused_addr_bits;

  assign req     = bus.mem_read | bus.mem_write;
  assign accept  = (state == IDLE) && req;
  // Abort tracks only the request line of the latched operation.
  assign op_held = op_w ? bus.mem_write : bus.mem_read;

  assign unused_addr_bits = ^bus.mem_addr[ADDR_W-1:DEPTH_LOG2];

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req) state_nx = (LATENCY == 1) ? RESP : BUSY;
      BUSY: begin
        if (!op_held)           state_nx = IDLE;
        else if (count == 8'd1) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        count <= COUNT_INIT;
        if (bus.mem_read && bus.mem_write) err_q <= 1'b1;
      end else if (state == BUSY) begin
        count <= count - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.mem_addr[DEPTH_LOG2-1:0];
      wdata_q <= bus.mem_wdata;
      op_w    <= bus.mem_write;
    end
  end

  // Gating with rst_n drops a write whose RESP edge coincides with reset.
  assign mem_we = (state == RESP) && op_w && rst_n;

  block_mem_array #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );

  assign bus.mem_ready = (state == RESP);
  assign bus.mem_rdata = ((state == RESP) && !op_w) ? arr_rdata : '0;
  assign bus.mem_err   = err_q;

endmodule

// File: tb/tb_block_mem_responder.sv
// Randomised scoreboard bench for block_mem_responder against an
// associative-array memory model with cycle-exact completion timing.
module tb_block_mem_responder;

  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  block_mem_responder_if #(.ADDR_W(28), .DATA_W(128)) bus ();

  block_mem_responder #(
    .ADDR_W    (28),
    .DATA_W    (128),
    .DEPTH_LOG2(10),
    .LATENCY   (LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [127:0] rdata;
    int           cycle;
  } exp_t;

  exp_t          sb[$];
  logic [127:0]  model[int];
  int            written[$];
  int            cyc        = 0;
  int            n_checks   = 0;
  int            n_fail     = 0;
  int            ready_seen = 0;
  logic          exp_err    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the head of the scoreboard in data
  // and in cycle; outside ready the read bus must be zero.
  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_ready === 1'b1) begin
      ready_seen++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready at cycle %0d: got 1 expected 0", cyc);
      end else begin
        e = sb.pop_front();
        check("rdata", bus.mem_rdata, e.rdata);
        check("ready_cycle", 128'(cyc), 128'(e.cycle));
      end
    end else begin
      check("ready_low", {127'd0, bus.mem_ready}, '0);
      check("idle_rdata", bus.mem_rdata, '0);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input bit rd, input bit wr, input logic [27:0] addr,
                     input logic [127:0] wd);
    exp_t e;
    int   idx;
    int   t0;
    idx           = int'(addr[9:0]);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.mem_addr  = addr;
    bus.mem_wdata = wd;
    e.cycle = cyc + LAT;
    e.rdata = wr ? 128'd0 : model[idx];
    if (rd && wr) exp_err = 1'b1;
    sb.push_back(e);
    if (wr) model[idx] = wd;
    t0 = ready_seen;
    for (int i = 0; i < 300 && ready_seen == t0; i++) begin
      @(negedge clk);
      #1;
    end
    if (ready_seen == t0) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout addr %h: got no ready expected ready", addr);
      sb.delete();
    end
    next_cycle();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    check("err_flag", {127'd0, bus.mem_err}, {127'd0, exp_err});
  endtask

  task automatic note_written(input int idx);
    foreach (written[i]) if (written[i] == idx) return;
    written.push_back(idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] dead;
    logic [127:0] d;
    int           t0;
    int           idx;
    logic [27:0]  a;
    dead = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

    rst_n         = 1'b0;
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b0;
    bus.mem_addr  = 28'h3;
    bus.mem_wdata = '0;
    repeat (3) begin
      @(negedge clk);
      check("reset_err", {127'd0, bus.mem_err}, '0);
      check("reset_ready", {127'd0, bus.mem_ready}, '0);
    end
    next_cycle();
    bus.mem_read = 1'b0;
    rst_n        = 1'b1;
    next_cycle();

    // Write then read, including back-to-back read after write.
    txn(1'b0, 1'b1, 28'h5, dead);
    txn(1'b1, 1'b0, 28'h5, '0);
    note_written(5);
    repeat (2) next_cycle();
    txn(1'b1, 1'b0, 28'h5, '0);

    // Upper address bits alias onto the same block.
    d = {4{32'hA5A5_0405}};
    txn(1'b0, 1'b1, 28'h405, d);
    txn(1'b1, 1'b0, 28'h005, '0);

    // Abort: read held for two cycles then dropped.
    t0            = ready_seen;
    bus.mem_read  = 1'b1;
    bus.mem_addr  = 28'h9;
    repeat (2) next_cycle();
    bus.mem_read  = 1'b0;
    repeat (LAT + 3) next_cycle();
    check("abort_no_ready", 128'(ready_seen), 128'(t0));
    d = {4{32'h0900_1234}};
    txn(1'b0, 1'b1, 28'h9, d);
    note_written(9);
    txn(1'b1, 1'b0, 28'h9, '0);

    // Simultaneous read and write is a write and raises the sticky error.
    d = {4{32'h7777_0007}};
    txn(1'b1, 1'b1, 28'h7, d);
    note_written(7);
    txn(1'b1, 1'b0, 28'h7, '0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        idx = int'($urandom_range(0, 1023));
        a   = {18'($urandom), 10'(idx)};
        d   = {$urandom, $urandom, $urandom, $urandom};
        txn(1'b0, 1'b1, a, d);
        note_written(idx);
      end else begin
        idx = written[$urandom_range(0, written.size() - 1)];
        a   = {18'($urandom), 10'(idx)};
        txn(1'b1, 1'b0, a, '0);
      end
      repeat ($urandom_range(0, 2)) next_cycle();
    end

    // Reset in the middle of a write: nothing committed, error cleared.
    t0            = ready_seen;
    bus.mem_write = 1'b1;
    bus.mem_addr  = 28'h5;
    bus.mem_wdata = {4{32'hBAD0_BAD0}};
    repeat (2) next_cycle();
    bus.mem_write = 1'b0;
    rst_n         = 1'b0;
    next_cycle();
    rst_n         = 1'b1;
    exp_err       = 1'b0;
    check("reset_clears_err", {127'd0, bus.mem_err}, '0);
    repeat (LAT + 2) next_cycle();
    check("reset_no_ready", 128'(ready_seen), 128'(t0));
    txn(1'b1, 1'b0, 28'h5, '0);

    repeat (2) next_cycle();
    check("scoreboard_empty", 128'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
